ram_arb_mp: RTL and testbench
=============================

Name: ram_arb_mp

Overview:
Parametrised multi-requester, single-physical-port synchronous RAM.
- NUM_PORTS independent requesters each drive a valid/ready request channel and receive a one-cycle-latency response.
- A round-robin arbiter grants at most one request per cycle.
- Writes support per-byte enables.
- After reset, a clear engine zeroes the array one word per cycle before the block accepts traffic.
- Replaces the single-master combinational-read RAM on the UART memory path.

Parameters:
ADDR_WIDTH, 4, word address width; DEPTH = 2**ADDR_WIDTH.
DATA_WIDTH, 32, word width; must be a multiple of 8; BE_WIDTH = DATA_WIDTH/8.
NUM_PORTS, 2, number of requesters; legal range 1..8.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  synchronous, active-high reset.
req_valid  in  [NUM_PORTS]  request present, per port.
req_ready  out  [NUM_PORTS]  request accepted this cycle, per port.
req_wr  in  [NUM_PORTS]  1 = write, 0 = read.
req_addr  in  [NUM_PORTS][ADDR_WIDTH]  word address.
req_wdata  in  [NUM_PORTS][DATA_WIDTH]  write data.
req_be  in  [NUM_PORTS][BE_WIDTH]  byte enables (writes only).
rsp_valid  out  [NUM_PORTS]  one-cycle response pulse.
rsp_rdata  out  [NUM_PORTS][DATA_WIDTH]  response data.
init_done  out  1  high once the array clear completes.

Behaviour:
- Reset (rst high at a clock edge):
  - State goes to INIT with clear counter 0.
  - req_ready = 0, rsp_valid = 0, rsp_rdata = 0, init_done = 0.
  - Round-robin pointer set so port 0 has highest priority.
  - rst has priority over every other event.
- INIT:
  - Each cycle writes 0 to mem[counter], then increments the counter.
  - After writing DEPTH-1, moves to RUN and sets init_done = 1 on the same edge.
  - INIT lasts exactly DEPTH cycles after rst deasserts.
  - req_ready is held 0 throughout.
  - rst asserted during INIT restarts the clear at address 0.
- RUN:
  - Grant is combinational from req_valid and the pointer.
  - The first valid port at or after the pointer is granted; req_ready is high only for the granted port, and only when its req_valid is high.
  - Accept = req_valid & req_ready; at most one accept per cycle.
  - On accept, the pointer moves to (granted + 1) mod NUM_PORTS. With no accept, the pointer holds.
  - Non-granted requesters must hold their request stable until accepted.
- Write accept:
  - Each byte b with req_be[b] = 1 is updated at the next edge; other bytes are unchanged.
  - be = 0 writes nothing but still acknowledges.
  - The cycle after accept: rsp_valid[port] = 1 and rsp_rdata[port] = the merged (new) word.
- Read accept:
  - The cycle after accept: rsp_valid[port] = 1 and rsp_rdata[port] = mem[addr] as of the accept edge.
  - A read accepted the cycle after a write to the same address returns the new data.
- Responses:
  - rsp_valid is a single-cycle pulse; there is no response backpressure.
  - rsp_rdata[port] holds its last value until the next response on that port.
- Addresses: full range 0..DEPTH-1 is valid; no out-of-range case exists.
- Reset mid-operation: an in-flight response is dropped (rsp_valid is forced to 0) and the array is re-cleared.

Decomposition:
- Package ram_arb_pkg holds:
  - typedef enum {INIT, RUN} ram_state_e
  - BE_WIDTH derivation function
  - byte-merge function (old, new, be) -> merged word
- Sub-module rr_arbiter holds the pointer register and the grant logic.
  - Parameter: NUM_PORTS.
  - Ports: clk, rst, req, advance, gnt one-hot.
  - Reused by later multi-master blocks.

Test Plan:
1. Defaults; deassert rst; poll init_done -> init_done rises exactly 16 cycles later, req_ready stays 0 until then; reads of addr 0..15 all return 0x00000000.
2. Port 0 writes 0xAABBCCDD to addr 3 with be=4'b1111, then writes 0x11223344 with be=4'b0101; port 0 then reads addr 3 -> write acks carry 0xAABBCCDD then 0xAA22CC44; the read returns 0xAA22CC44 one cycle after accept.
3. Both ports hold req_valid high for 6 reads (port 0 addr 1, port 1 addr 2; mem[1]=0x1, mem[2]=0x2) -> grants alternate 0,1,0,1,0,1; each rsp_valid pulses the cycle after its own accept with the correct data; port 0 never gets two consecutive grants.
4. Port 1 writes 0xDEADBEEF to addr 15; port 0 reads addr 15 the next cycle; port 0 then reads addr 0 -> addr 15 read returns 0xDEADBEEF; addr 0 read returns 0 (no wrap aliasing).
5. Write 0x12345678 to addr 5; assert rst for 1 cycle in the cycle after accept -> the ack is suppressed (rsp_valid stays 0) and init_done drops; after 16 cycles, a read of addr 5 returns 0.
6. NUM_PORTS=1, DATA_WIDTH=8: continuous read/write requests -> an accept every cycle after init; each response arrives exactly 1 cycle after its accept.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the arbitrated single-port RAM and its relatives.
// Widths up to MAX_DATA_WIDTH bits are supported by the byte-merge helper.
package ram_arb_pkg;

    typedef enum logic {INIT, RUN} ram_state_e;

    localparam int MAX_DATA_WIDTH = 256;
    localparam int MAX_BE_WIDTH   = MAX_DATA_WIDTH / 8;

    function automatic int be_width(input int data_width);
        return data_width / 8;
    endfunction

    // Byte b of the result comes from new_word when be[b] is set, else from old_word.
    function automatic logic [MAX_DATA_WIDTH-1:0] merge_bytes(
        input logic [MAX_DATA_WIDTH-1:0] old_word,
        input logic [MAX_DATA_WIDTH-1:0] new_word,
        input logic [MAX_BE_WIDTH-1:0]   be
    );
        logic [MAX_DATA_WIDTH-1:0] res;
        res = old_word;
        for (int b = 0; b < MAX_BE_WIDTH; b++) begin
            if (be[b]) res[b*8 +: 8] = new_word[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/ram_arb_mp_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer.
// The pointer moves past the granted port whenever advance is high.
module rr_arbiter #(
    parameter int NUM_PORTS = 2
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 advance,
    output logic [NUM_PORTS-1:0] gnt
);

    // Three bits cover the full 1..8 port range, even for a single port.
    logic [2:0] ptr_q;
    int         gnt_idx;
    logic       found;

    always_comb begin
        gnt     = '0;
        gnt_idx = 0;
        found   = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            for (int j = 0; j < NUM_PORTS; j++) begin
                if (!found && req[j] && (j == (int'(ptr_q) + i) % NUM_PORTS)) begin
                    gnt[j]  = 1'b1;
                    gnt_idx = j;
                    found   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (advance && found) begin
            ptr_q <= 3'((gnt_idx + 1) % NUM_PORTS);
        end
    end

endmodule

// File: rtl/ram_arb_mp.sv
// Multi-requester RAM behind a round-robin arbiter, cleared word-by-word after reset.
// Handshake: a request transfers on a cycle where req_valid[p] & req_ready[p]; the
// requester holds its fields stable until then; rsp_valid[p] pulses the next cycle.
module ram_arb_mp
    import ram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_PORTS  = 2,
    localparam int BE_WIDTH  = be_width(DATA_WIDTH)
)(
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_PORTS-1:0]                  req_valid,
    output logic [NUM_PORTS-1:0]                  req_ready,
    input  logic [NUM_PORTS-1:0]                  req_wr,
    input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  req_wdata,
    input  logic [NUM_PORTS-1:0][BE_WIDTH-1:0]    req_be,
    output logic [NUM_PORTS-1:0]                  rsp_valid,
    output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  rsp_rdata,
    output logic                                  init_done
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    ram_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]  mem [DEPTH];

    logic [NUM_PORTS-1:0]   gnt;
    logic                   accept;
    logic                   sel_wr;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [DATA_WIDTH-1:0]  sel_wdata;
    logic [BE_WIDTH-1:0]    sel_be;
    logic [DATA_WIDTH-1:0]  merged;
    logic [DATA_WIDTH-1:0]  rsp_word;
    logic [NUM_PORTS-1:0]   rsp_valid_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ADDR) state_d = RUN;
            end
            RUN: state_d = RUN;
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign init_done = (state_q == RUN);

    rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid & {NUM_PORTS{init_done}}),
        .advance (accept),
        .gnt     (gnt)
    );

    assign req_ready = gnt;
    assign accept    = |gnt;

    always_comb begin
        sel_wr    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_be    = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (gnt[p]) begin
                sel_wr    = req_wr[p];
                sel_addr  = req_addr[p];
                sel_wdata = req_wdata[p];
                sel_be    = req_be[p];
            end
        end
    end

    assign merged   = DATA_WIDTH'(merge_bytes(MAX_DATA_WIDTH'(mem[sel_addr]),
                                              MAX_DATA_WIDTH'(sel_wdata),
                                              MAX_BE_WIDTH'(sel_be)));
    assign rsp_word = sel_wr ? merged : mem[sel_addr];

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == INIT) mem[cnt_q] <= '0;
            else if (accept && sel_wr) mem[sel_addr] <= merged;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= '0;
            rsp_rdata   <= '0;
        end else begin
            rsp_valid_q <= gnt;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (gnt[p]) rsp_rdata[p] <= rsp_word;
            end
        end
    end

    // A response pending while reset is asserted is dropped, not delivered late.
    assign rsp_valid = rsp_valid_q & ~{NUM_PORTS{rst}};

endmodule

// File: tb/tb_ram_arb_mp.sv
// Directed bench for ram_arb_mp: a 2-port/32-bit instance and a 1-port/8-bit instance.
module tb_ram_arb_mp;

    logic clk;
    logic rst;

    logic [1:0]       req_valid, req_ready, req_wr, rsp_valid;
    logic [1:0][3:0]  req_addr, req_be;
    logic [1:0][31:0] req_wdata, rsp_rdata;
    logic             init_done;

    logic [0:0]       v1, rdy1, wr1, rv1;
    logic [0:0][3:0]  a1;
    logic [0:0][7:0]  wd1, rd1;
    logic [0:0][0:0]  be1;
    logic             done1;

    int n_cmp;
    int n_bad;
    logic [31:0] exp_q[$];

    ram_arb_mp #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .NUM_PORTS(2)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .init_done(init_done)
    );

    ram_arb_mp #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .NUM_PORTS(1)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(v1), .req_ready(rdy1),
        .req_wr(wr1), .req_addr(a1), .req_wdata(wd1), .req_be(be1),
        .rsp_valid(rv1), .rsp_rdata(rd1), .init_done(done1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Counts edges after rst falls until both instances report init_done.
    task automatic wait_init(input string tag);
        int cycles;
        cycles = 0;
        while (!init_done && cycles < 40) begin
            @(posedge clk);
            #1;
            cycles++;
            if (!init_done) check({tag, "_ready_low"}, 64'(req_ready), 64'h0);
        end
        req_valid = '0;
        check({tag, "_cycles"}, 64'(cycles), 64'd16);
        check({tag, "_done1"}, 64'(done1), 64'h1);
    endtask

    // One transaction on port p; checks the response that follows its accept.
    task automatic xact(input int p, input logic wr, input logic [3:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input logic [31:0] exp, input string tag);
        int waited;
        @(negedge clk);
        req_wr[p]    = wr;
        req_addr[p]  = addr;
        req_wdata[p] = wdata;
        req_be[p]    = be;
        req_valid[p] = 1'b1;
        #1;
        waited = 0;
        while (!req_ready[p] && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (waited >= 20) begin
            check({tag, "_timeout"}, 64'(waited), 64'd0);
            req_valid[p] = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            req_valid[p] = 1'b0;
            check({tag, "_rsp_valid"}, 64'(rsp_valid[p]), 64'h1);
            check({tag, "_rdata"}, 64'(rsp_rdata[p]), 64'(exp));
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        req_valid = '0; req_wr = '0; req_addr = '0; req_wdata = '0; req_be = '0;
        v1 = '0; wr1 = '0; a1 = '0; wd1 = '0; be1 = '0;

        // 1: reset state, clear length, array reads back zero
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_init_done", 64'(init_done), 64'h0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        check("rst_rsp_rdata", 64'(rsp_rdata), 64'h0);
        req_valid = 2'b11;
        #1;
        check("rst_req_ready", 64'(req_ready), 64'h0);
        rst = 1'b0;
        wait_init("init");
        for (int a = 0; a < 16; a++) xact(0, 1'b0, 4'(a), 32'h0, 4'h0, 32'h0, "clr_read");

        // 2: full write then partial byte-enable merge
        xact(0, 1'b1, 4'd3, 32'hAABBCCDD, 4'b1111, 32'hAABBCCDD, "wr_full");
        xact(0, 1'b1, 4'd3, 32'h11223344, 4'b0101, 32'hAA22CC44, "wr_part");
        xact(0, 1'b0, 4'd3, 32'h0, 4'h0, 32'hAA22CC44, "rd_merged");
        xact(0, 1'b1, 4'd3, 32'hFFFFFFFF, 4'b0000, 32'hAA22CC44, "wr_be0");

        // 3: contention; last accepts on port 1 leave port 0 with priority
        xact(1, 1'b1, 4'd1, 32'h1, 4'hF, 32'h1, "set_m1");
        xact(1, 1'b1, 4'd2, 32'h2, 4'hF, 32'h2, "set_m2");
        @(negedge clk);
        req_wr = 2'b00;
        req_addr[0] = 4'd1;
        req_addr[1] = 4'd2;
        req_valid = 2'b11;
        #1;
        for (int k = 0; k < 6; k++) begin
            logic [1:0] eg;
            int         gp;
            gp = k % 2;
            eg = (gp == 0) ? 2'b01 : 2'b10;
            check("rr_grant", 64'(req_ready), 64'(eg));
            @(posedge clk);
            #1;
            if (k == 5) req_valid = 2'b00;
            check("rr_rsp_valid", 64'(rsp_valid), 64'(eg));
            check("rr_rdata", 64'(rsp_rdata[gp]), 64'(gp + 1));
        end
        @(posedge clk);
        #1;
        check("rr_idle", 64'(rsp_valid), 64'h0);

        // 4: top address, read-after-write, no aliasing onto address 0
        xact(1, 1'b1, 4'd15, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF, "wr_top");
        xact(0, 1'b0, 4'd15, 32'h0, 4'h0, 32'hDEADBEEF, "rd_top");
        xact(0, 1'b0, 4'd0, 32'h0, 4'h0, 32'h0, "rd_zero");
        check("hold_rdata", 64'(rsp_rdata[1]), 64'hDEADBEEF);

        // 5: reset right after a write accept drops the ack and re-clears
        @(negedge clk);
        req_wr[0] = 1'b1;
        req_addr[0] = 4'd5;
        req_wdata[0] = 32'h12345678;
        req_be[0] = 4'hF;
        req_valid[0] = 1'b1;
        #1;
        check("mid_ready", 64'(req_ready), 64'h1);
        @(posedge clk);
        #1;
        req_valid = '0;
        rst = 1'b1;
        #1;
        check("mid_rsp_drop", 64'(rsp_valid), 64'h0);
        @(posedge clk);
        #1;
        check("mid_done_low", 64'(init_done), 64'h0);
        check("mid_rsp_after", 64'(rsp_valid), 64'h0);
        check("mid_rdata_rst", 64'(rsp_rdata), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        wait_init("reinit");
        xact(0, 1'b0, 4'd5, 32'h0, 4'h0, 32'h0, "rd5_clr");
        xact(1, 1'b0, 4'd3, 32'h0, 4'h0, 32'h0, "rd3_clr");

        // 6: single 8-bit port accepts every cycle, responses one cycle later
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            v1[0]  = 1'b1;
            wr1[0] = (k % 2 == 0);
            a1[0]  = 4'(k / 2);
            wd1[0] = 8'(8'h10 + k);
            be1[0] = 1'b1;
            exp_q.push_back((k % 2 == 0) ? 32'(8'h10 + k) : 32'(8'h10 + k - 1));
            #1;
            check("p1_ready", 64'(rdy1), 64'h1);
            @(posedge clk);
            #1;
            check("p1_rsp_valid", 64'(rv1), 64'h1);
            if (exp_q.size() > 0) check("p1_rdata", 64'(rd1[0]), 64'(exp_q.pop_front()));
        end
        @(negedge clk);
        v1 = '0;
        @(posedge clk);
        #1;
        check("p1_idle", 64'(rv1), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
